fully_connect_backward: RTL and testbench
=========================================

# fully_connect_backward

Backward-pass engine for the fully connected layer: given the layer input X, weights W and the upstream gradient dY, it computes the input gradient dX = dY·Wᵀ, the weight gradient dW = Xᵀ·dY and the bias gradient db = column sums of dY. It is the training-direction counterpart of the forward fully connected layer and uses the same parameters and array shapes. It uses one time-multiplexed multiply-accumulate (MAC) unit under a start/busy/done handshake, trading latency for area.

## Interface
- batch_size, default 1: rows of X and dY (B)
- feature_size, default 3: columns of X, rows of W (F)
- bias_size, default 2: columns of W and dY (N)

Ports:
- clk  input  1: single clock, rising edge
- rst  input  1: asynchronous, active-high reset
- start  input  1: begin a backward pass; sampled only in IDLE
- data  input  [31:0] [B][F]: layer input X
- weight  input  [31:0] [F][N]: weight matrix W
- grad_out  input  [31:0] [B][N]: upstream gradient dY
- grad_data  output  [31:0] [B][F]: dX
- grad_weight  output  [31:0] [F][N]: dW
- grad_bias  output  [31:0] [N]: db
- busy  output  1: high while computing
- done  output  1: one-cycle pulse when all gradients are final

## Operation
- Arithmetic: signed 32-bit two's complement throughout.
  - Each product keeps the low 32 bits of the full product.
  - Accumulation wraps modulo 2³².
  - No saturation and no overflow flag.
- Input capture: at the clock edge where start=1 in IDLE, data, weight and grad_out are copied into internal registers. Inputs may change freely afterwards.
- FSM states: IDLE → CALC_DB → CALC_DW → CALC_DX → DONE → IDLE.
  - IDLE: busy=0, done=0. start=1 moves to CALC_DB.
  - CALC_DB: db[n] = Σ_b dY[b][n], with n outer and b inner. Takes N·B cycles.
  - CALC_DW: dW[f][n] = Σ_b X[b][f]·dY[b][n], with f outer, then n, then b inner. Takes F·N·B cycles.
  - CALC_DX: dX[b][f] = Σ_n dY[b][n]·W[f][n], with b outer, then f, then n inner. Takes B·F·N cycles.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE unconditionally.
- CALC_DB uses the MAC with its multiplier operand forced to 1.
- One MAC operation per cycle, with no idle cycles between elements or between phases.
  - First term of an element: the accumulator loads the product.
  - Middle terms: the accumulator adds the product.
  - Last term: the sum (accumulator + product) is written directly to the output register element.
  - When the sum has a single term (B=1 in the DB/DW phases, N=1 in the DX phase), that term is both first and last and is written directly.
- Outputs are written element by element during busy. Values are guaranteed correct only from the done cycle onward, and are held until the next start completes the matching element.
- start while busy=1 or done=1 is ignored; it is not queued.

## Timing
- Reset (asynchronous assert): state=IDLE, busy=0, done=0; all of grad_data, grad_weight, grad_bias, the accumulator and the captured inputs are 0.
- Reset mid-operation aborts the pass immediately. No done is produced, and outputs read 0.
- Start at edge t0:
  - busy=1 from t0 through t0+T, where T = B·N·(1+2F).
  - The final output is written at edge t0+T.
  - done=1 in the cycle after edge t0+T.
  - With default parameters, T=14.
- Back-to-back passes: the earliest accepted start is in the first IDLE cycle after done. Start held high continuously produces one pass every T+2 cycles.
- No combinational path from any input to any output.

## Test plan
1. Defaults, X=[1,2,3], W=[[1,2],[3,4],[5,6]], dY=[10,−1], start pulse → busy for exactly 14 cycles, then done for 1 cycle; db=[10,−1], dW=[[10,−1],[20,−2],[30,−3]], dX=[8,26,44].
2. batch_size=2, X=[[1,0,0],[0,1,0]], W all 1, dY=[[1,1],[2,2]] → db=[3,3], dW=[[1,1],[2,2],[0,0]], dX=[[2,2,2],[4,4,4]], T=28.
3. Overflow, defaults: X=[32'h4000_0000,0,0], dY=[4,0], W all 0 → dW[0][0]=0 (wrapped), db=[4,0], dX=[0,0,0].
4. Change data, weight and grad_out every cycle after the start edge → results equal those computed from the values captured at start; start pulses during busy produce no extra pass or done.
5. Assert rst at cycle 5 of a pass → busy, done and all outputs are 0 immediately. A fresh start after release gives the case-1 results in 14 cycles.
6. start held high for 40 cycles with constant case-1 inputs → done pulses exactly at cycles 15 and 31 after the first start edge, with identical results each time.

Source files
------------

// File: rtl/fully_connect_backward.sv
// fully_connect_backward: FC-layer backward pass (db, dW, dX) on one time-multiplexed MAC
module fully_connect_backward #(
    parameter int batch_size   = 1,
    parameter int feature_size = 3,
    parameter int bias_size    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] data        [batch_size][feature_size],
    input  logic [31:0] weight      [feature_size][bias_size],
    input  logic [31:0] grad_out    [batch_size][bias_size],
    output logic [31:0] grad_data   [batch_size][feature_size],
    output logic [31:0] grad_weight [feature_size][bias_size],
    output logic [31:0] grad_bias   [bias_size],
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {IDLE, CALC_DB, CALC_DW, CALC_DX, DONE} state_t;

    state_t      state_q;
    logic [31:0] x_q  [batch_size][feature_size];
    logic [31:0] w_q  [feature_size][bias_size];
    logic [31:0] dy_q [batch_size][bias_size];
    logic [31:0] acc_q, i_q, j_q, k_q;
    logic [31:0] ni, nj, nk, op_a, op_b, prod, sum;
    logic        i_last, j_last, k_last;

    // Loop bounds of the current phase: i outer, j middle, k inner (summed) index
    always_comb begin
        ni = state_q == CALC_DB ? bias_size : state_q == CALC_DW ? feature_size : batch_size;
        nj = state_q == CALC_DB ? 1 : state_q == CALC_DW ? bias_size : feature_size;
        nk = state_q == CALC_DX ? bias_size : batch_size;
        i_last = i_q == ni - 1;
        j_last = j_q == nj - 1;
        k_last = k_q == nk - 1;
    end

    // MAC operand selection; the bias phase sums dY by forcing the multiplier to 1
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int b = 0; b < batch_size; b++)
            for (int n = 0; n < bias_size; n++) begin
                if (state_q == CALC_DB && k_q == b && i_q == n) op_a = dy_q[b][n];
                if (state_q == CALC_DW && k_q == b && j_q == n) op_b = dy_q[b][n];
                if (state_q == CALC_DX && i_q == b && k_q == n) op_a = dy_q[b][n];
            end
        for (int b = 0; b < batch_size; b++)
            for (int f = 0; f < feature_size; f++)
                if (state_q == CALC_DW && k_q == b && i_q == f) op_a = x_q[b][f];
        for (int f = 0; f < feature_size; f++)
            for (int n = 0; n < bias_size; n++)
                if (state_q == CALC_DX && j_q == f && k_q == n) op_b = w_q[f][n];
        if (state_q == CALC_DB) op_b = 32'd1;
        prod = op_a * op_b;
        sum  = (k_q == 0 ? '0 : acc_q) + prod;
    end

    // Control FSM, input capture, accumulator and element-wise output write-back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            acc_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            x_q         <= '{default: '0};
            w_q         <= '{default: '0};
            dy_q        <= '{default: '0};
            grad_data   <= '{default: '0};
            grad_weight <= '{default: '0};
            grad_bias   <= '{default: '0};
        end else begin
            for (int n = 0; n < bias_size; n++)
                if (state_q == CALC_DB && k_last && i_q == n) grad_bias[n] <= sum;
            for (int f = 0; f < feature_size; f++)
                for (int n = 0; n < bias_size; n++)
                    if (state_q == CALC_DW && k_last && i_q == f && j_q == n) grad_weight[f][n] <= sum;
            for (int b = 0; b < batch_size; b++)
                for (int f = 0; f < feature_size; f++)
                    if (state_q == CALC_DX && k_last && i_q == b && j_q == f) grad_data[b][f] <= sum;
            case (state_q)
                IDLE: if (start) begin
                    x_q     <= data;
                    w_q     <= weight;
                    dy_q    <= grad_out;
                    i_q     <= '0;
                    j_q     <= '0;
                    k_q     <= '0;
                    busy    <= 1'b1;
                    state_q <= CALC_DB;
                end
                CALC_DB, CALC_DW, CALC_DX: begin
                    acc_q <= sum;
                    if (!k_last) k_q <= k_q + 1;
                    else begin
                        k_q <= '0;
                        if (!j_last) j_q <= j_q + 1;
                        else begin
                            j_q <= '0;
                            if (!i_last) i_q <= i_q + 1;
                            else begin
                                i_q     <= '0;
                                busy    <= state_q != CALC_DX;
                                done    <= state_q == CALC_DX;
                                state_q <= state_q == CALC_DB ? CALC_DW : state_q == CALC_DW ? CALC_DX : DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fully_connect_backward.sv
// tb_fully_connect_backward: directed checks of the FC backward engine
module tb_fully_connect_backward;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [31:0] d0 [1][3], w0 [3][2], g0 [1][2], gd0 [1][3], gw0 [3][2], gb0 [2];
    logic [31:0] d1 [2][3], w1 [3][2], g1 [2][2], gd1 [2][3], gw1 [3][2], gb1 [2];
    logic        busy0, done0, busy1, done1;
    logic [31:0] e_db [2], e_dw [3][2], e_dx [3];
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    fully_connect_backward u0 (
        .clk(clk), .rst(rst), .start(start0), .data(d0), .weight(w0), .grad_out(g0),
        .grad_data(gd0), .grad_weight(gw0), .grad_bias(gb0), .busy(busy0), .done(done0)
    );

    fully_connect_backward #(.batch_size(2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .data(d1), .weight(w1), .grad_out(g1),
        .grad_data(gd1), .grad_weight(gw1), .grad_bias(gb1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
    endtask

    task automatic set_case1();
        d0 = '{'{32'd1, 32'd2, 32'd3}};
        w0 = '{'{32'd1, 32'd2}, '{32'd3, 32'd4}, '{32'd5, 32'd6}};
        g0 = '{'{32'd10, -32'sd1}};
        e_db = '{32'd10, -32'sd1};
        e_dw = '{'{32'd10, -32'sd1}, '{32'd20, -32'sd2}, '{32'd30, -32'sd3}};
        e_dx = '{32'd8, 32'd26, 32'd44};
    endtask

    task automatic check_res(input string p);
        for (int n = 0; n < 2; n++) chk($sformatf("%s_db%0d", p, n), gb0[n], e_db[n]);
        for (int f = 0; f < 3; f++)
            for (int n = 0; n < 2; n++) chk($sformatf("%s_dw%0d%0d", p, f, n), gw0[f][n], e_dw[f][n]);
        for (int f = 0; f < 3; f++) chk($sformatf("%s_dx%0d", p, f), gd0[0][f], e_dx[f]);
    endtask

    task automatic do_pass(input string p);
        int cnt = 0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        while (busy0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk({p, "_busy_len"}, cnt, 14);
        chk({p, "_done"}, {31'd0, done0}, 1);
        check_res(p);
        @(negedge clk);
        chk({p, "_done_pulse"}, {31'd0, done0}, 0);
    endtask

    initial begin
        int cnt, nd, first, second;
        set_case1();
        d1 = '{default: '0};
        w1 = '{default: '0};
        g1 = '{default: '0};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy0}, 0);
        chk("rst_done", {31'd0, done0}, 0);
        chk("rst_db0", gb0[0], 0);
        chk("rst_dw00", gw0[0][0], 0);
        chk("rst_dx0", gd0[0][0], 0);

        do_pass("c1");

        d0 = '{'{32'h4000_0000, 32'd0, 32'd0}};
        w0 = '{default: '0};
        g0 = '{'{32'd4, 32'd0}};
        e_db = '{32'd4, 32'd0};
        e_dw = '{default: '0};
        e_dx = '{default: '0};
        do_pass("c3");

        set_case1();
        cnt = 0;
        start0 = 1'b1;
        @(negedge clk);
        while (busy0 && cnt < 200) begin
            cnt++;
            start0 = cnt[0];
            d0 = '{'{$urandom, $urandom, $urandom}};
            w0 = '{'{$urandom, $urandom}, '{$urandom, $urandom}, '{$urandom, $urandom}};
            g0 = '{'{$urandom, $urandom}};
            @(negedge clk);
        end
        start0 = 1'b0;
        chk("c4_busy_len", cnt, 14);
        chk("c4_done", {31'd0, done0}, 1);
        check_res("c4");
        nd = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            nd += int'(busy0) + int'(done0);
        end
        chk("c4_no_extra", nd, 0);

        set_case1();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("c5_busy", {31'd0, busy0}, 0);
        chk("c5_done", {31'd0, done0}, 0);
        chk("c5_db0", gb0[0], 0);
        chk("c5_dw00", gw0[0][0], 0);
        chk("c5_dx0", gd0[0][0], 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_pass("c5");

        nd = 0;
        first = 0;
        second = 0;
        start0 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done0) begin
                nd++;
                if (nd == 1) first = c;
                if (nd == 2) second = c;
                check_res($sformatf("c6_%0d", nd));
            end
        end
        start0 = 1'b0;
        chk("c6_done_cnt", nd, 2);
        chk("c6_first", first, 15);
        chk("c6_second", second, 31);
        cnt = 0;
        while ((busy0 || done0) && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("c6_idle", {31'd0, busy0}, 0);

        d1 = '{'{32'd1, 32'd0, 32'd0}, '{32'd0, 32'd1, 32'd0}};
        w1 = '{default: 32'd1};
        g1 = '{'{32'd1, 32'd1}, '{32'd2, 32'd2}};
        cnt = 0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (busy1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("c2_busy_len", cnt, 28);
        chk("c2_done", {31'd0, done1}, 1);
        for (int n = 0; n < 2; n++) chk($sformatf("c2_db%0d", n), gb1[n], 3);
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("c2_dw0%0d", n), gw1[0][n], 1);
            chk($sformatf("c2_dw1%0d", n), gw1[1][n], 2);
            chk($sformatf("c2_dw2%0d", n), gw1[2][n], 0);
        end
        for (int f = 0; f < 3; f++) begin
            chk($sformatf("c2_dx0%0d", f), gd1[0][f], 2);
            chk($sformatf("c2_dx1%0d", f), gd1[1][f], 4);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
